// File: rtl/branch_pred_cache.sv
// Direct-mapped, tag-checked lookup table for the branch predictor.
// Two independent combinational read ports and one synchronous write port.
// Each line holds a valid bit, a tag and a DWIDTH payload in flops.
//
// Read ports: there is no handshake. An address presented on raN produces
// hitN/doutN in the same cycle. A write with we=1 is accepted on every
// rising edge unless reset is high.
module branch_pred_cache #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 2,
    parameter int LINES  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    output logic [DWIDTH-1:0] dout0,
    output logic              hit0,
    input  logic [AWIDTH-1:0] ra1,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit1,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] din,
    input  logic              we
);

    localparam int IW = $clog2(LINES);
    localparam int TW = AWIDTH - IW;

    // Per-line storage. Only the valid bits are reset; a miss forces the
    // data output to zero, so stale tag/data contents never leak out.
    logic [LINES-1:0]  r_valid;
    logic [TW-1:0]     r_tag  [LINES];
    logic [DWIDTH-1:0] r_data [LINES];

    // Address split for each port.
    logic [IW-1:0] w_idx0;
    logic [IW-1:0] w_idx1;
    logic [IW-1:0] w_widx;
    logic [TW-1:0] w_tag0;
    logic [TW-1:0] w_tag1;
    logic [TW-1:0] w_wtag;
    logic          w_wr_en;

    assign w_idx0  = ra0[IW-1:0];
    assign w_idx1  = ra1[IW-1:0];
    assign w_widx  = wa[IW-1:0];
    assign w_tag0  = ra0[AWIDTH-1:IW];
    assign w_tag1  = ra1[AWIDTH-1:IW];
    assign w_wtag  = wa[AWIDTH-1:IW];
    // Reset wins over a simultaneous write; the write is simply dropped.
    assign w_wr_en = we && !reset;

    // Valid bits: cleared by reset, set by an accepted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (we) begin
            r_valid[w_widx] <= 1'b1;
        end
    end

    // Tag and payload arrays: written on an accepted write, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag[w_widx]  <= w_wtag;
            r_data[w_widx] <= din;
        end
    end

    // Port 0 lookup: no bypass, so a same-cycle write is not visible yet.
    always_comb begin
        hit0  = r_valid[w_idx0] && (r_tag[w_idx0] == w_tag0);
        dout0 = hit0 ? r_data[w_idx0] : {DWIDTH{1'b0}};
    end

    // Port 1 lookup, independent of port 0.
    always_comb begin
        hit1  = r_valid[w_idx1] && (r_tag[w_idx1] == w_tag1);
        dout1 = hit1 ? r_data[w_idx1] : {DWIDTH{1'b0}};
    end

endmodule

// File: tb/tb_branch_pred_cache.sv
// Directed bench for branch_pred_cache (AWIDTH=30, DWIDTH=2, LINES=128).
// The driver applies one cycle of inputs at a time and, when a check is
// requested, pushes the hand-computed expected outputs into exp_q. The
// monitor samples the combinational outputs on the falling edge and pops.
module tb_branch_pred_cache;

    localparam int AW = 30;
    localparam int DW = 2;
    localparam int EW = 2 * (DW + 1);

    // clock / reset block
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] ra0 = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] wa  = '0;
    logic [DW-1:0] din = '0;
    logic          we  = 1'b0;
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic          hit0;
    logic          hit1;

    always #5 clk = ~clk;

    branch_pred_cache #(.AWIDTH(AW), .DWIDTH(DW), .LINES(128)) dut (
        .clk   (clk),
        .reset (reset),
        .ra0   (ra0),
        .dout0 (dout0),
        .hit0  (hit0),
        .ra1   (ra1),
        .dout1 (dout1),
        .hit1  (hit1),
        .wa    (wa),
        .din   (din),
        .we    (we)
    );

    localparam logic [AW-1:0] A = 30'b0101_0101_0101_0101_0101_0101_1111_11; // idx 127
    localparam logic [AW-1:0] B = A | (30'd1 << 29);                        // idx 127, other tag
    localparam logic [AW-1:0] C = 30'h0ABCD00;                              // idx 0
    localparam logic [AW-1:0] D = 30'h155507F;                              // idx 127
    localparam logic [AW-1:0] E = D ^ (30'd1 << 7);                         // idx 127, other tag

    // scoreboard: {hit0, dout0, hit1, dout1}
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            passed = 0;
    logic          chk = 1'b0;

    task automatic cmp(input string nm, input string fld, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    endtask

    // monitor: outputs are combinational, sampled mid-cycle
    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL monitor: output presented with no expected entry (got 0 wanted 1 entries)");
            end else begin
                logic [EW-1:0] e;
                string         nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "hit0",  int'(hit0),  int'(e[EW-1]));
                cmp(nm, "dout0", int'(dout0), int'(e[EW-2 -: DW]));
                cmp(nm, "hit1",  int'(hit1),  int'(e[DW]));
                cmp(nm, "dout1", int'(dout1), int'(e[DW-1:0]));
            end
        end
    end

    // driver: one cycle of inputs, optional check, then advance past the edge
    task automatic cycle(input string nm, input logic rst, input logic w_en,
                         input logic [AW-1:0] w_a, input logic [DW-1:0] w_d,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic do_chk, input logic e_h0, input logic [DW-1:0] e_d0,
                         input logic e_h1, input logic [DW-1:0] e_d1);
        reset = rst;
        we    = w_en;
        wa    = w_a;
        din   = w_d;
        ra0   = a0;
        ra1   = a1;
        if (do_chk) begin
            exp_q.push_back({e_h0, e_d0, e_h1, e_d1});
            name_q.push_back(nm);
            chk = 1'b1;
        end
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // 1. hold reset, then everything misses
        for (int i = 0; i < 3; i++) cycle("rst", 1, 0, '0, '0, A, A, 0, 0, 0, 0, 0);
        cycle("after_reset", 0, 0, '0, '0, A, A, 1, 0, 2'b00, 0, 2'b00);
        cycle("reset_other", 0, 0, '0, '0, C, D, 1, 0, 2'b00, 0, 2'b00);
        // 2. allocate A; no bypass during the write cycle
        cycle("alloc_cycle", 0, 1, A, 2'b01, A, A, 1, 0, 2'b00, 0, 2'b00);
        cycle("alloc_read", 0, 0, '0, '0, A, A, 1, 1, 2'b01, 1, 2'b01);
        // 3. same-tag overwrite: old data during the cycle, new after
        cycle("upd_cycle", 0, 1, A, 2'b11, A, A, 1, 1, 2'b01, 1, 2'b01);
        cycle("upd_read", 0, 0, '0, '0, A, A, 1, 1, 2'b11, 1, 2'b11);
        // 4. different tag on same index misses, then evicts A
        cycle("b_miss", 0, 0, '0, '0, B, B, 1, 0, 2'b00, 0, 2'b00);
        cycle("b_wr_cycle", 0, 1, B, 2'b10, B, A, 1, 0, 2'b00, 1, 2'b11);
        cycle("b_evict", 0, 0, '0, '0, B, A, 1, 1, 2'b10, 0, 2'b00);
        // X read address with we=0 must not disturb state
        cycle("x_read", 0, 0, '0, '0, 'x, 'x, 0, 0, 0, 0, 0);
        cycle("after_x", 0, 0, '0, '0, B, B, 1, 1, 2'b10, 1, 2'b10);
        // 5. one-cycle reset; contents still visible until the edge
        cycle("rst_cycle", 1, 0, '0, '0, B, B, 1, 1, 2'b10, 1, 2'b10);
        cycle("rst_cleared", 0, 0, '0, '0, B, A, 1, 0, 2'b00, 0, 2'b00);
        cycle("rst_we", 1, 1, A, 2'b01, A, B, 0, 0, 0, 0, 0);
        cycle("rst_we_drop", 0, 0, '0, '0, A, B, 1, 0, 2'b00, 0, 2'b00);
        // 6. index 0 and index 127, read independently on both ports
        cycle("wr_c", 0, 1, C, 2'b10, '0, '0, 0, 0, 0, 0, 0);
        cycle("wr_d", 0, 1, D, 2'b01, C, D, 1, 1, 2'b10, 0, 2'b00);
        cycle("two_idx", 0, 0, '0, '0, C, D, 1, 1, 2'b10, 1, 2'b01);
        cycle("two_idx_swap", 0, 0, '0, '0, D, C, 1, 1, 2'b01, 1, 2'b10);
        cycle("tag_mismatch", 0, 0, '0, '0, E, C, 1, 0, 2'b00, 1, 2'b10);
        cycle("idle", 0, 0, '0, '0, '0, '0, 0, 0, 0, 0, 0);
        // every pushed expectation must have been consumed
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // safety bound on total run time
    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, got %0d/%0d", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
